// File: rtl/sys_io_pkg.sv
// Shared types and constants for the controller serial receiver.
// Optional feature macro: CTRL_CHECKSUM_EN adds a trailing XOR checksum byte
// and the CHECK state that validates it.
package sys_io_pkg;

  localparam logic [7:0] CTRL_HEADER_DEFAULT = 8'hA5;
  localparam int         CTRL_PAYLOAD_BYTES  = 3;

  typedef struct packed {
    logic [7:0] buttons;
    logic [7:0] joystick_x;
    logic [7:0] joystick_y;
  } controller_state_t;

  typedef enum logic [1:0] {
    RX_HUNT    = 2'd0,
`ifdef CTRL_CHECKSUM_EN
    RX_PAYLOAD = 2'd1,
    RX_CHECK   = 2'd2
`else
    RX_PAYLOAD = 2'd1
`endif
  } rx_state_t;

`ifdef CTRL_CHECKSUM_EN
  function automatic logic [7:0] ctrl_checksum(input controller_state_t s);
    return s.buttons ^ s.joystick_x ^ s.joystick_y;
  endfunction
`endif

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input plus a rising-edge pulse
// derived from the synchronized level.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic sync,
  output logic rise
);

  logic meta;
  logic sync_q;
  logic prev;

  // Metastability chain and one-cycle history of the synchronized level
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
      prev   <= 1'b0;
    end else begin
      meta   <= raw;
      sync_q <= meta;
      prev   <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev;

endmodule

// File: rtl/controller_spi_rx.sv
// Serial receiver for a game controller: assembles MSB-first bytes from an
// asynchronous clock/data pair, frames HEADER + buttons/X/Y packets and
// publishes them atomically with a one-cycle packet_valid pulse.
// Optional feature macro: CTRL_CHECKSUM_EN (fourth payload byte = XOR of the
// three data bytes, mismatches are counted as frame errors).
module controller_spi_rx
  import sys_io_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 10000,
  parameter logic [7:0] HEADER         = CTRL_HEADER_DEFAULT
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       chip_clk_raw,
  input  logic       chip_data_raw,
  output logic [7:0] buttons,
  output logic [7:0] joystick_x,
  output logic [7:0] joystick_y,
  output logic       packet_valid,
  output logic [7:0] last_raw_byte,
  output logic [7:0] frame_errors
);

  localparam int               IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [1:0]       LAST_IDX = 2'(CTRL_PAYLOAD_BYTES - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic serial_clk_sync_unused;
  logic serial_clk_rise;
  logic serial_data;
  logic serial_data_rise_unused;

  logic [2:0]        bit_cnt;
  logic [7:0]        shift_q;
  logic [IDLE_W-1:0] idle_cnt;
  logic [7:0]        raw_byte_q;
  logic [7:0]        byte_next;
  logic              byte_done;
  logic              timeout;

  rx_state_t         state;
  logic [1:0]        idx;
  controller_state_t shadow;
  controller_state_t out_q;
  logic              valid_q;
  logic [7:0]        errors_q;

  sync_edge_detect u_clk_sync (
    .clk  (clk_in),
    .rst  (rst_in),
    .raw  (chip_clk_raw),
    .sync (serial_clk_sync_unused),
    .rise (serial_clk_rise)
  );

  sync_edge_detect u_data_sync (
    .clk  (clk_in),
    .rst  (rst_in),
    .raw  (chip_data_raw),
    .sync (serial_data),
    .rise (serial_data_rise_unused)
  );

  // Both paths share the same synchronizer latency, so serial_data is the bit
  // that was present when the serial clock rose.
  assign byte_next = {shift_q[6:0], serial_data};
  assign byte_done = serial_clk_rise && (bit_cnt == 3'd7);
  // An edge on the timeout cycle wins: it is sampled instead of aborting.
  assign timeout   = (idle_cnt == IDLE_MAX) && !serial_clk_rise;

  // Bit assembly, idle watchdog and raw byte capture
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bit_cnt    <= 3'd0;
      shift_q    <= 8'd0;
      idle_cnt   <= '0;
      raw_byte_q <= 8'd0;
    end else if (serial_clk_rise) begin
      bit_cnt  <= bit_cnt + 3'd1;
      shift_q  <= byte_next;
      idle_cnt <= '0;
      if (bit_cnt == 3'd7) begin
        raw_byte_q <= byte_next;
      end
    end else begin
      if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (timeout) begin
        bit_cnt <= 3'd0;
        shift_q <= 8'd0;
      end
    end
  end

  // Payload bytes staged here so partial packets never reach the outputs
  always_ff @(posedge clk_in) begin
    if (byte_done && state == RX_PAYLOAD) begin
      case (idx)
        2'd0:    shadow.buttons    <= byte_next;
        2'd1:    shadow.joystick_x <= byte_next;
        default: shadow.joystick_y <= byte_next;
      endcase
    end
  end

  // Packet framing FSM with registered outputs; commit lands on the same
  // clock edge that captures the final raw byte
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= RX_HUNT;
      idx      <= 2'd0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      errors_q <= 8'd0;
    end else begin
      valid_q <= 1'b0;
      if (timeout && state != RX_HUNT) begin
        state    <= RX_HUNT;
        errors_q <= sat_inc8(errors_q);
      end else if (byte_done) begin
        case (state)
          RX_HUNT: begin
            if (byte_next == HEADER) begin
              state <= RX_PAYLOAD;
              idx   <= 2'd0;
            end
          end
          RX_PAYLOAD: begin
            if (idx == LAST_IDX) begin
`ifdef CTRL_CHECKSUM_EN
              state <= RX_CHECK;
`else
              out_q   <= '{buttons:    shadow.buttons,
                           joystick_x: shadow.joystick_x,
                           joystick_y: byte_next};
              valid_q <= 1'b1;
              state   <= RX_HUNT;
`endif
            end else begin
              idx <= idx + 2'd1;
            end
          end
`ifdef CTRL_CHECKSUM_EN
          RX_CHECK: begin
            if (byte_next == ctrl_checksum(shadow)) begin
              out_q   <= shadow;
              valid_q <= 1'b1;
            end else begin
              errors_q <= sat_inc8(errors_q);
            end
            state <= RX_HUNT;
          end
`endif
          default: state <= RX_HUNT;
        endcase
      end
    end
  end

  assign buttons       = out_q.buttons;
  assign joystick_x    = out_q.joystick_x;
  assign joystick_y    = out_q.joystick_y;
  assign packet_valid  = valid_q;
  assign last_raw_byte = raw_byte_q;
  assign frame_errors  = errors_q;

endmodule

// File: tb/tb_controller_spi_rx.sv
// Scoreboard bench for controller_spi_rx: expected packets are queued when a
// packet is sent and checked by a monitor whenever packet_valid pulses.
module tb_controller_spi_rx;

  localparam int TO   = 64;
  localparam int HALF = 4;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       chip_clk_raw = 1'b0;
  logic       chip_data_raw = 1'b0;
  logic [7:0] buttons;
  logic [7:0] joystick_x;
  logic [7:0] joystick_y;
  logic       packet_valid;
  logic [7:0] last_raw_byte;
  logic [7:0] frame_errors;

  controller_spi_rx #(.TIMEOUT_CYCLES(TO), .HEADER(8'hA5)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .chip_clk_raw  (chip_clk_raw),
    .chip_data_raw (chip_data_raw),
    .buttons       (buttons),
    .joystick_x    (joystick_x),
    .joystick_y    (joystick_y),
    .packet_valid  (packet_valid),
    .last_raw_byte (last_raw_byte),
    .frame_errors  (frame_errors)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0] b;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] raw;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every commit must match the oldest queued expectation
  always @(negedge clk_in) begin
    if (!rst_in && packet_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_commit: got %h/%h/%h expected no commit",
                 buttons, joystick_x, joystick_y);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check8("commit_buttons", buttons, e.b);
        check8("commit_joy_x", joystick_x, e.x);
        check8("commit_joy_y", joystick_y, e.y);
        check8("commit_raw", last_raw_byte, e.raw);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      chip_data_raw = v[i];
      idle(HALF);
      chip_clk_raw = 1'b1;
      idle(HALF);
      chip_clk_raw = 1'b0;
    end
  endtask

  task automatic send_packet(input logic [7:0] b, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e.b = b;
    e.x = x;
    e.y = y;
`ifdef CTRL_CHECKSUM_EN
    e.raw = b ^ x ^ y;
`else
    e.raw = y;
`endif
    sb.push_back(e);
    send_byte(8'hA5);
    send_byte(b);
    send_byte(x);
    send_byte(y);
`ifdef CTRL_CHECKSUM_EN
    send_byte(b ^ x ^ y);
`endif
    idle(20);
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s: got %0d uncommitted packets expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [7:0] exp_err;

    // Reset state
    rst_in = 1'b1;
    idle(5);
    check8("rst_buttons", buttons, 8'h00);
    check8("rst_joy_x", joystick_x, 8'h00);
    check8("rst_joy_y", joystick_y, 8'h00);
    check8("rst_raw", last_raw_byte, 8'h00);
    check8("rst_errors", frame_errors, 8'h00);
    check8("rst_valid", {7'd0, packet_valid}, 8'h00);
    rst_in = 1'b0;
    idle(5);

    // Basic packet
    send_packet(8'h12, 8'h34, 8'h56);
    check_drained("pkt_basic");
    check8("basic_errors", frame_errors, 8'h00);

    // Garbage before header is ignored silently
    send_byte(8'h00);
    send_byte(8'hFF);
    send_packet(8'h01, 8'h02, 8'h03);
    check_drained("pkt_after_garbage");
`ifdef CTRL_CHECKSUM_EN
    check8("garbage_raw", last_raw_byte, 8'h00);
`else
    check8("garbage_raw", last_raw_byte, 8'h03);
`endif
    check8("garbage_errors", frame_errors, 8'h00);

    // Timeout mid-packet aborts without publishing
    send_byte(8'hA5);
    send_byte(8'h11);
    idle(TO + 5);
    check8("timeout_errors", frame_errors, 8'h01);
    check8("timeout_held_buttons", buttons, 8'h01);
    send_packet(8'h21, 8'h22, 8'h23);
    check_drained("pkt_after_timeout");
    check8("post_timeout_errors", frame_errors, 8'h01);

    // Reset mid-packet
    send_byte(8'hA5);
    send_byte(8'h44);
    rst_in = 1'b1;
    idle(3);
    check8("midrst_buttons", buttons, 8'h00);
    check8("midrst_joy_x", joystick_x, 8'h00);
    check8("midrst_joy_y", joystick_y, 8'h00);
    check8("midrst_raw", last_raw_byte, 8'h00);
    check8("midrst_errors", frame_errors, 8'h00);
    check8("midrst_valid", {7'd0, packet_valid}, 8'h00);
    rst_in = 1'b0;
    idle(3);
    send_packet(8'h07, 8'h08, 8'h09);
    check_drained("pkt_after_reset");
    check8("post_reset_errors", frame_errors, 8'h00);
    exp_err = 8'h00;

`ifdef CTRL_CHECKSUM_EN
    // Checksum match commits, mismatch is rejected and counted
    send_packet(8'h01, 8'h02, 8'h04);
    check_drained("pkt_checksum_ok");
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h04);
    send_byte(8'h00);
    idle(20);
    check8("cks_bad_errors", frame_errors, 8'h01);
    check8("cks_bad_held_buttons", buttons, 8'h01);
    check8("cks_bad_held_joy_y", joystick_y, 8'h04);
    exp_err = 8'h01;
`endif

    // Error counter saturation under repeated timeouts
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hA5);
      idle(TO + 5);
      if (i == 9) begin
        check8("errors_after_10", frame_errors, exp_err + 8'd10);
      end
    end
    check8("errors_saturated", frame_errors, 8'hFF);
    send_packet(8'hAA, 8'hBB, 8'hCC);
    check_drained("pkt_after_saturation");
    check8("errors_still_saturated", frame_errors, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
